// File: rtl/md5_pkg.sv
// Shared MD5 constants and helpers for the forward compression core and the
// reverse-round inverter: K table, per-step shift schedule, round function,
// message word index and word packing.
package md5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rev_state_e;

    localparam logic [31:0] K_TABLE [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rows are rounds, columns are step_index[1:0].
    localparam logic [4:0] SHIFT_TABLE [4][4] = '{
        '{5'd7, 5'd12, 5'd17, 5'd22},
        '{5'd5, 5'd9,  5'd14, 5'd20},
        '{5'd4, 5'd11, 5'd16, 5'd23},
        '{5'd6, 5'd10, 5'd15, 5'd21}
    };

    function automatic logic [4:0] shift_amt(input logic [5:0] step);
        return SHIFT_TABLE[step[5:4]][step[1:0]];
    endfunction

    function automatic logic [31:0] round_f(input logic [1:0] rnd, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        logic [31:0] res;
        res = '0;
        case (rnd)
            2'd0: res = (b & c) | (~b & d);
            2'd1: res = (d & b) | (~d & c);
            2'd2: res = b ^ c ^ d;
            2'd3: res = c ^ (b | ~d);
        endcase
        return res;
    endfunction

    // 4-bit arithmetic wraps mod 16, which is exactly the schedule's modulus.
    function automatic logic [3:0] msg_index(input logic [5:0] step);
        logic [3:0] ii;
        logic [3:0] res;
        ii  = step[3:0];
        res = ii;
        case (step[5:4])
            2'd0: res = ii;
            2'd1: res = ii * 4'd5 + 4'd1;
            2'd2: res = ii * 4'd3 + 4'd5;
            2'd3: res = ii * 4'd7;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] get_word(input logic [511:0] blk, input logic [3:0] j);
        return blk[{j, 5'd0} +: 32];
    endfunction

    function automatic logic [127:0] pack_state(input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

endpackage

// File: rtl/right_rotate.sv
// Step-indexed right rotate; undoes the forward core's left rotate for the
// same step index.
module right_rotate
    import md5_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [5:0]  step_index,
    output logic [31:0] data_out
);

    logic [4:0] sh;

    // Shift amount never reaches 0, so the 32-s left shift stays in range.
    always_comb begin
        sh       = shift_amt(step_index);
        data_out = (data_in >> sh) | (data_in << (6'd32 - {1'b0, sh}));
    end

endmodule

// File: rtl/md5_reverse_rounds.sv
// Iterative MD5 round inverter: one inverse compression step per clock,
// step 63 down to step 0, returning the state that entered step 0.
//
// state | meaning
// IDLE  | waiting for start, state_out holds last result
// RUN   | applying inverse of step i, i counts 63 -> 0
// DONE  | result valid, done pulses for one cycle
module md5_reverse_rounds
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] state_in,
    input  logic [511:0] block_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out
);

    rev_state_e   fsm_q, fsm_d;
    logic [5:0]   step_q, step_d;
    logic [31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [511:0] blk_q, blk_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0]  diff_bc;
    logic [31:0]  t_rot;
    logic [31:0]  a_prev;

    right_rotate u_rotate (
        .data_in    (diff_bc),
        .step_index (step_q),
        .data_out   (t_rot)
    );

    // Inverse step datapath: recover A from the rotated sum, registers shift back.
    always_comb begin
        diff_bc = b_q - c_q;
        a_prev  = t_rot
                - round_f(step_q[5:4], c_q, d_q, a_q)
                - K_TABLE[step_q]
                - get_word(blk_q, msg_index(step_q));
    end

    // Sequencer next-state: accept in IDLE/DONE, step down in RUN.
    always_comb begin
        fsm_d  = fsm_q;
        step_d = step_q;
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        d_d    = d_q;
        blk_d  = blk_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (fsm_q)
            ST_IDLE, ST_DONE: begin
                fsm_d  = ST_IDLE;
                busy_d = 1'b0;
                if (start) begin
                    a_d    = state_in[31:0];
                    b_d    = state_in[63:32];
                    c_d    = state_in[95:64];
                    d_d    = state_in[127:96];
                    blk_d  = block_in;
                    step_d = 6'd63;
                    busy_d = 1'b1;
                    fsm_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d    = a_prev;
                b_d    = c_q;
                c_d    = d_q;
                d_d    = a_q;
                step_d = step_q - 6'd1;
                if (step_q == 6'd0) begin
                    fsm_d  = ST_DONE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                fsm_d  = ST_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    // State registers; reset clears everything including the latched block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            step_q <= 6'd0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            blk_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            step_q <= step_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            d_q    <= d_d;
            blk_q  <= blk_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = pack_state(a_q, b_q, c_q, d_q);

endmodule

// File: doc/md5_reverse_rounds.md
# md5_reverse_rounds

Iterative MD5 round inverter: given the working state (A,B,C,D) after all 64 compression steps and the 512-bit message block, it undoes the steps one per clock, from step 63 down to step 0, and returns the state that entered step 0. It is the inverse datapath to the forward compression core. Its per-step right rotation uses the same step-indexed shift schedule as the forward core's left rotation. Verification uses it to cross-check the forward core and to recover chaining values.

## Interface
Parameters: none. Widths are fixed by MD5.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request. Sampled only in IDLE or DONE.
- `state_in` in 128: post-step-63 state. A = [31:0], B = [63:32], C = [95:64], D = [127:96].
- `block_in` in 512: message words M[0..15]. M[j] = bits [32j+31:32j], little-endian words as in MD5.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when the result is valid.
- `state_out` out 128: recovered pre-step-0 state, same packing as `state_in`. Held until the next accepted start.

## Operation
FSM states: IDLE, RUN, DONE.
- IDLE/DONE + `start`: latch `state_in` into the A/B/C/D registers, latch `block_in`, set step counter i=63, go to RUN.
- RUN: each cycle apply the inverse of step i, then decrement i.
  - If i==0 on that cycle, go to DONE.
- DONE: `done`=1 for exactly one cycle.
  - Next state is RUN if `start` is high, else IDLE.

Inverse of step i, with (A',B',C',D') the current registers:
- B = C', C = D', D = A'.
- T = rotr(B' − C', s[i]).
- A = T − f_r(B,C,D) − K[i] − M[g(i)].
- All arithmetic is mod 2^32.

Round r = i[5:4]:
- r0: f = (B&C)|(~B&D), g = i.
- r1: f = (D&B)|(~D&C), g = (5i+1) mod 16.
- r2: f = B^C^D, g = (3i+5) mod 16.
- r3: f = C^(B|~D), g = 7i mod 16.

Shift schedule, s[i] selected by i[1:0] within round r:
- r0: 7, 12, 17, 22
- r1: 5, 9, 14, 20
- r2: 4, 11, 16, 23
- r3: 6, 10, 15, 21

K[i] = floor(2^32·|sin(i+1)|). Endpoints: K[0] = 0xd76aa478, K[63] = 0xeb86d391.

Boundary rules:
- `start` during RUN is ignored. Latched block and state are not disturbed.
- `state_in`/`block_in` changes after the accepted start have no effect.
- `state_out` is the working register set. It is only architecturally valid when `done` pulses and while in IDLE afterwards.
- `rst` at any time, including mid-RUN:
  - FSM goes to IDLE and i = 0.
  - Registers clear: `state_out` = 0, `busy` = 0, `done` = 0.
  - The latched block is cleared.

## Timing
- Reset values: `busy` = 0, `done` = 0, `state_out` = 128'h0.
- Start accepted at edge k:
  - `busy` is high after edges k .. k+63.
  - Step 63 is applied at edge k+1 and step 0 at edge k+64.
  - `done` is high in the cycle after edge k+64.
- Latency is 64 cycles from the accepted start edge to the `done` cycle.
- Throughput is one block per 65 cycles. Back-to-back operation uses `start` in the DONE cycle.
- One full inverse step fits in a single cycle. The step is combinational from registers.

## Structure
- Package `md5_pkg` holds:
  - K[0..63] constant array.
  - Shift table s[round][i[1:0]].
  - Round function f_r.
  - Message index function g(i).
  - Word-packing helpers.
- The forward compression core uses the same package.
- Sub-module `right_rotate` (data_in[31:0], step_index[5:0], data_out[31:0]):
  - Looks up s[step_index] from the package.
  - Rotates right: (x >> s) | (x << (32−s)).
  - It is the exact inverse of the forward left rotate for the same step_index.

## Test plan
- Empty-message block (M[0] = 0x00000080, M[1..15] = 0):
  - Input: state_in = {D 0x6E10A476, C 0xFF4EA3EB, B 0x14E45506, A 0x7246FAD3}.
  - Required: `state_out` = IV {0x10325476, 0x98badcfe, 0xefcdab89, 0x67452301} with `done` 65 cycles after start.
- Round-trip against a golden forward model: 200 random (IV, block) pairs.
  - Forward the pair through the golden model, feed the result in.
  - Required: `state_out` == IV every time, `done` exactly one cycle each.
- `start` pulsed at RUN cycles 1, 30 and 63:
  - Required: no restart, latency stays 64, result matches the undisturbed run.
- `rst` asserted at RUN cycle 20:
  - Required: `busy`/`done`/`state_out` are 0 immediately, asynchronously.
  - A new start after reset release gives the correct result.
- Back-to-back: `start` held high through the DONE cycle with a second vector.
  - Required: the second `done` arrives 65 cycles after the first, and both results are correct.
- Rotation unit check:
  - Input: `right_rotate` data_in = 0x80000001, step_index = 0 (s = 7).
  - Required: 0x03000000.
  - Step_index 63 (s = 21) is the exact inverse of the forward left rotate for 16 random words.
